// File: rtl/da_rom_loader.sv
// Purpose: collects TAPS signed coefficients and streams all 2^TAPS DA partial sums into the coefficient ROM.
// Latency: load_done pulses 2^TAPS+1 cycles after the cycle that follows the last coefficient handshake.
// Backpressure: coef_ready is high only while collecting; hold freezes streaming without skipping or repeating entries.
// Optional: define DA_ROM_CHECKSUM_EN to add the rom_csum output (running signed sum of every written entry).
module da_rom_loader #(
  parameter int TAPS   = 4,
  parameter int COEF_W = 8,
  parameter int SUM_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_req,
  input  logic                     coef_valid,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_ready,
  input  logic                     hold,
  output logic                     CLOAD,
  output logic [TAPS-1:0]          rom_addr,
  output logic [SUM_W-1:0]         rom_data,
`ifdef DA_ROM_CHECKSUM_EN
  output logic [SUM_W+TAPS-1:0]    rom_csum,
`endif
  output logic                     busy,
  output logic                     load_done
);

  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                   state;
  logic [TAP_W-1:0]         tap_cnt;
  // One extra bit: k[TAPS] set means every entry has been issued.
  logic [TAPS:0]            k;
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [SUM_W-1:0]  sum_k;

  // Partial sum for the current entry: coefficients selected by the set bits of k.
  always_comb begin
    sum_k = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (k[i]) begin
        sum_k = sum_k + SUM_W'(coef[i]);
      end
    end
  end

  // Load sequencer: state, coefficient capture, entry counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tap_cnt    <= '0;
      k          <= '0;
      coef_ready <= 1'b0;
      CLOAD      <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_req) begin
            state      <= S_COLLECT;
            coef_ready <= 1'b1;
            busy       <= 1'b1;
            tap_cnt    <= '0;
          end
        end
        S_COLLECT: begin
          if (coef_valid && coef_ready) begin
            coef[tap_cnt] <= coef_data;
            tap_cnt       <= tap_cnt + 1'b1;
            if (tap_cnt == TAP_W'(TAPS - 1)) begin
              state      <= S_STREAM;
              coef_ready <= 1'b0;
              k          <= '0;
            end
          end
        end
        S_STREAM: begin
          if (k[TAPS]) begin
            // Last entry is on the bus this cycle; finish regardless of hold.
            CLOAD     <= 1'b0;
            load_done <= 1'b1;
            state     <= S_DONE;
          end else if (hold) begin
            // Address and data stay put so the bus is stable while frozen.
            CLOAD <= 1'b0;
          end else begin
            CLOAD    <= 1'b1;
            rom_addr <= k[TAPS-1:0];
            rom_data <= sum_k;
            k        <= k + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DA_ROM_CHECKSUM_EN
  localparam int CSUM_W = SUM_W + TAPS;

  // Running signed sum of every entry written; restarts when a new load is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_csum <= '0;
    end else if (state == S_IDLE && load_req) begin
      rom_csum <= '0;
    end else if (CLOAD) begin
      rom_csum <= rom_csum + CSUM_W'($signed(rom_data));
    end
  end
`endif

endmodule

// File: tb/tb_da_rom_loader.sv
// Bench for da_rom_loader: directed test-plan loads plus randomized loads against a reference model.
// The model derives each ROM entry as a plain sum of the selected coefficients and the checksum as 2^(TAPS-1)*sum(coef).
`timescale 1ns/1ps
module tb_da_rom_loader;
  localparam int TAPS   = 4;
  localparam int COEF_W = 8;
  localparam int SUM_W  = 10;
  localparam int DEPTH  = 1 << TAPS;
  localparam int BASE_LAT = DEPTH + 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     load_req;
  logic                     coef_valid;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_ready;
  logic                     hold;
  logic                     CLOAD;
  logic [TAPS-1:0]          rom_addr;
  logic [SUM_W-1:0]         rom_data;
`ifdef DA_ROM_CHECKSUM_EN
  logic [SUM_W+TAPS-1:0]    rom_csum;
`endif
  logic                     busy;
  logic                     load_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_cyc = 0;
  int done_busy = 0;
  int done_cload = 0;
  int wr_a[$];
  int wr_d[$];
  int cap_q[$];
  int gap_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  da_rom_loader #(.TAPS(TAPS), .COEF_W(COEF_W), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .coef_valid(coef_valid),
    .coef_data (coef_data),
    .coef_ready(coef_ready),
    .hold      (hold),
    .CLOAD     (CLOAD),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
`ifdef DA_ROM_CHECKSUM_EN
    .rom_csum  (rom_csum),
`endif
    .busy      (busy),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Passive monitor on the falling edge: ROM writes, handshakes, load_done pulses.
  always @(negedge clk) begin
    if (CLOAD === 1'b1) begin
      wr_a.push_back(int'(rom_addr));
      wr_d.push_back(int'($signed(rom_data)));
    end
    if (load_done === 1'b1) begin
      done_cnt++;
      done_cyc   = cyc;
      done_busy  = int'(busy);
      done_cload = int'(CLOAD);
    end
    if (coef_valid === 1'b1 && coef_ready === 1'b1) begin
      hs_cyc = cyc;
      cap_q.push_back(int'(coef_data));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_entry(input int c[TAPS], input int k);
    int s = 0;
    for (int i = 0; i < TAPS; i++) begin
      if (((k >> i) & 1) == 1) s += c[i];
    end
    return s;
  endfunction

  function automatic int model_csum(input int c[TAPS]);
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += c[i];
    return (DEPTH / 2) * s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_d.delete();
    cap_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("busy_in_collect", int'(busy), 1);
    chk("coef_ready_in_collect", int'(coef_ready), 1);
  endtask

  // mode 0: valid held high, 1: fixed gap pattern, 2: random gaps
  task automatic send_coefs(input int c[TAPS], input int mode, input bit poke_req);
    int idx = 0;
    int guard = 0;
    bit v;
    while (idx < TAPS && guard < 200) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (gap_pat[guard % 7] == 1);
      else v = ($urandom_range(0, 1) == 1);
      coef_valid = v;
      coef_data  = COEF_W'(c[idx]);
      load_req   = poke_req && (idx == 1);
      chk("coef_ready_high_while_collecting", int'(coef_ready), 1);
      if (v && coef_ready === 1'b1) idx++;
      step();
      guard++;
    end
    coef_valid = 1'b0;
    load_req   = 1'b0;
    chk("coef_handshake_timeout", idx, TAPS);
    chk("coef_ready_drop", int'(coef_ready), 0);
  endtask

  task automatic wait_done(input int hold_addr, input int hold_len, input bit poke_req, input bit rand_hold);
    int guard = 0;
    int hold_left = 0;
    bit hold_used = 1'b0;
    while (done_cnt == 0 && guard < 300) begin
      hold     = 1'b0;
      load_req = 1'b0;
      if (hold_left > 0) begin
        hold = 1'b1;
        hold_left--;
      end else if (hold_addr >= 0 && !hold_used && CLOAD === 1'b1 && int'(rom_addr) == hold_addr) begin
        hold      = 1'b1;
        hold_left = hold_len - 1;
        hold_used = 1'b1;
      end
      if (rand_hold) hold = ($urandom_range(0, 3) == 0);
      if (poke_req && (guard == 3 || guard == 9)) load_req = 1'b1;
      step();
      guard++;
    end
    hold     = 1'b0;
    load_req = 1'b0;
    chk("load_done_timeout", int'(done_cnt > 0), 1);
  endtask

  task automatic check_load(input string tag, input int c[TAPS], input int exp_lat);
    chk({tag, "_write_count"}, wr_a.size(), DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("%s_addr[%0d]", tag, k), wr_a[k], k);
      chk($sformatf("%s_data[%0d]", tag, k), wr_d[k], model_entry(c, k));
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, done_busy, 1);
    chk({tag, "_cload_at_done"}, done_cload, 0);
    if (exp_lat >= 0) chk({tag, "_latency"}, done_cyc - hs_cyc - 1, exp_lat);
    chk({tag, "_coef_count"}, cap_q.size(), TAPS);
    for (int i = 0; i < TAPS; i++) begin
      chk($sformatf("%s_coef[%0d]", tag, i), cap_q[i], c[i]);
    end
`ifdef DA_ROM_CHECKSUM_EN
    chk({tag, "_checksum"}, int'($signed(rom_csum)), model_csum(c));
`endif
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_load_done_after"}, int'(load_done), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_coef_ready"}, int'(coef_ready), 0);
    chk({tag, "_cload"}, int'(CLOAD), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_rom_data"}, int'(rom_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_load_done"}, int'(load_done), 0);
`ifdef DA_ROM_CHECKSUM_EN
    chk({tag, "_csum"}, int'(rom_csum), 0);
`endif
  endtask

  initial begin
    int c[TAPS];
    int guard;

    reset = 1'b1; load_req = 1'b0; coef_valid = 1'b0; coef_data = '0; hold = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Basic load
    c = '{1, 2, 3, 4};
    clear_mon(); start_load(); send_coefs(c, 0, 1'b0); wait_done(-1, 0, 1'b0, 1'b0);
    check_load("basic", c, BASE_LAT);
    chk("basic_s0", wr_d[0], 0);
    chk("basic_s5", wr_d[5], 4);
    chk("basic_s10", wr_d[10], 6);
    chk("basic_s15", wr_d[15], 10);

    // Negative extreme
    c = '{-128, -128, -128, -128};
    clear_mon(); start_load(); send_coefs(c, 0, 1'b0); wait_done(-1, 0, 1'b0, 1'b0);
    check_load("negext", c, BASE_LAT);
    chk("negext_s1", wr_d[1], -128);
    chk("negext_s15", wr_d[15], -512);
    chk("negext_raw15", int'(rom_data), 'h200);

    // Gapped coefficient input
    c = '{5, -7, 11, -3};
    clear_mon(); start_load(); send_coefs(c, 1, 1'b0); wait_done(-1, 0, 1'b0, 1'b0);
    check_load("gapped", c, BASE_LAT);

    // Hold for three cycles on address 6
    c = '{1, 2, 3, 4};
    clear_mon(); start_load(); send_coefs(c, 0, 1'b0); wait_done(6, 3, 1'b0, 1'b0);
    check_load("hold", c, BASE_LAT + 3);

    // Reset in the middle of streaming
    c = '{9, 8, 7, 6};
    clear_mon(); start_load(); send_coefs(c, 0, 1'b0);
    guard = 0;
    while (!(CLOAD === 1'b1 && int'(rom_addr) == 9) && guard < 50) begin
      step();
      guard++;
    end
    chk("midreset_reach_addr9", int'(rom_addr), 9);
    reset = 1'b1;
    step();
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (5) step();
    chk("midreset_no_done", done_cnt, 0);
    chk("midreset_idle_busy", int'(busy), 0);
    chk("midreset_idle_cload", int'(CLOAD), 0);
    clear_mon(); start_load(); send_coefs(c, 0, 1'b0); wait_done(-1, 0, 1'b0, 1'b0);
    check_load("reload", c, BASE_LAT);

    // load_req pulses during COLLECT and STREAM are ignored
    c = '{1, 2, 3, 4};
    clear_mon(); start_load(); send_coefs(c, 0, 1'b1); wait_done(-1, 0, 1'b1, 1'b0);
    check_load("ignreq", c, BASE_LAT);

    // Randomized loads with random gaps and random holds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < TAPS; i++) c[i] = int'($urandom_range(0, 255)) - 128;
      clear_mon(); start_load(); send_coefs(c, 2, 1'b0); wait_done(-1, 0, 1'b0, 1'b1);
      check_load($sformatf("rand%0d", r), c, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
